// File: rtl/fnd_pkg.sv
// fnd_pkg: segment patterns, digit codes, digit indices and FSM encoding for the scan receiver.
package fnd_pkg;
  localparam logic [3:0] DIG_BLANK   = 4'hF;
  localparam logic [3:0] DIG_ILLEGAL = 4'hE;
  localparam logic [6:0] SEG_0 = 7'h3F, SEG_1 = 7'h06, SEG_2 = 7'h5B, SEG_3 = 7'h4F, SEG_4 = 7'h66;
  localparam logic [6:0] SEG_5 = 7'h6D, SEG_6 = 7'h7D, SEG_7 = 7'h07, SEG_8 = 7'h7F, SEG_9 = 7'h6F;
  localparam logic [6:0] SEG_7_ALT = 7'h27, SEG_9_ALT = 7'h67, SEG_BLANK = 7'h00;
  localparam int IDX_S0 = 0, IDX_S10 = 1, IDX_M0 = 2, IDX_M10 = 3, IDX_H0 = 4, IDX_H10 = 5;
  typedef enum logic [1:0] {ST_IDLE, ST_SETTLE, ST_CAPTURE, ST_HOLD} state_e;
  function automatic logic [6:0] bcd2_to_bin(input logic [3:0] d1, input logic [3:0] d0);
    logic [6:0] a, b;
    a = (d1 > 4'd9) ? 7'd0 : {3'd0, d1};
    b = (d0 > 4'd9) ? 7'd0 : {3'd0, d0};
    return a * 7'd10 + b;
  endfunction
endpackage

// File: rtl/seg7_to_bcd.sv
// seg7_to_bcd: 7-segment pattern {g..a} to digit code; blank -> F, unknown -> E with illegal flag.
module seg7_to_bcd
  import fnd_pkg::*;
(
  input  logic [6:0] seg_i,
  output logic [3:0] code_o,
  output logic       illegal_o
);
  always_comb begin
    code_o = DIG_ILLEGAL;
    case (seg_i)
      SEG_0:            code_o = 4'd0;
      SEG_1:            code_o = 4'd1;
      SEG_2:            code_o = 4'd2;
      SEG_3:            code_o = 4'd3;
      SEG_4:            code_o = 4'd4;
      SEG_5:            code_o = 4'd5;
      SEG_6:            code_o = 4'd6;
      SEG_7, SEG_7_ALT: code_o = 4'd7;
      SEG_8:            code_o = 4'd8;
      SEG_9, SEG_9_ALT: code_o = 4'd9;
      SEG_BLANK:        code_o = DIG_BLANK;
      default:          code_o = DIG_ILLEGAL;
    endcase
  end
  assign illegal_o = code_o == DIG_ILLEGAL;
endmodule

// File: rtl/fnd_scan_rx.sv
// fnd_scan_rx: rebuilds BCD digits, dp mask and binary h/m/s from a 6-digit multiplexed 7-seg scan.
// FND_SCAN_RX_BLINK_HOLD_EN: blank captures keep the previous digit and are flagged on o_blank.
module fnd_scan_rx
  import fnd_pkg::*;
#(
  parameter int ENB_ACT_LOW = 1,
  parameter int SEG_ACT_LOW = 0,
  parameter int SETTLE_CYC  = 4,
  parameter int TIMEOUT_CYC = 50000
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [5:0]  i_seg_enb,
  input  logic [6:0]  i_seg,
  input  logic        i_seg_dp,
  output logic [23:0] o_digit,
  output logic [5:0]  o_dp,
  output logic [6:0]  o_hour,
  output logic [6:0]  o_min,
  output logic [6:0]  o_sec,
  output logic        o_frame_valid,
  output logic        o_err,
  output logic        o_stall
`ifdef FND_SCAN_RX_BLINK_HOLD_EN
  ,
  output logic [5:0]  o_blank
`endif
);
  localparam int CW = $clog2(SETTLE_CYC + 1);
  localparam int TW = $clog2(TIMEOUT_CYC + 1);
  logic [5:0] enb_q, last_q, cap_idx_q, mask_q, mask_d, dp_q, dp_d;
  logic [6:0] seg_q, cap_seg_q, hour_q, min_q, sec_q;
  logic dp_in_q, cap_dp_q, err_q, fv_q, onehot, multi, chg, capture, frame, illegal;
  logic [3:0] code;
  logic [5:0][3:0] digit_q, digit_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic [TW-1:0] stall_q;
  state_e state_q, state_d;
`ifdef FND_SCAN_RX_BLINK_HOLD_EN
  logic [5:0] blank_q, blank_d;
`endif
  assign onehot  = enb_q != 6'd0 && (enb_q & (enb_q - 6'd1)) == 6'd0;
  assign multi   = enb_q != 6'd0 && !onehot;
  assign chg     = enb_q != last_q;
  assign capture = state_q == ST_CAPTURE;
  seg7_to_bcd u_dec (.seg_i(cap_seg_q), .code_o(code), .illegal_o(illegal));
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    if (!onehot) state_d = ST_IDLE;
    else if (state_q == ST_IDLE || chg) begin
      state_d = ST_SETTLE;
      cnt_d   = CW'(1);
    end else if (state_q == ST_SETTLE) begin
      cnt_d   = cnt_q + CW'(1);
      state_d = (cnt_d == CW'(SETTLE_CYC)) ? ST_CAPTURE : ST_SETTLE;
    end else state_d = ST_HOLD;
  end
  always_comb begin
    digit_d = digit_q;
    dp_d    = dp_q;
    mask_d  = mask_q;
`ifdef FND_SCAN_RX_BLINK_HOLD_EN
    blank_d = blank_q;
`endif
    for (int i = 0; i < 6; i++) begin
      if (capture && cap_idx_q[i]) begin
`ifdef FND_SCAN_RX_BLINK_HOLD_EN
        digit_d[i] = (code == DIG_BLANK) ? digit_q[i] : code;
        blank_d[i] = code == DIG_BLANK;
`else
        digit_d[i] = code;
`endif
        dp_d[i]   = cap_dp_q;
        mask_d[i] = 1'b1;
      end
    end
    frame = mask_d == 6'h3F;
  end
  // The sample that completed the settle count is what CAPTURE decodes.
  always_ff @(posedge clk) begin
    if (state_q == ST_SETTLE) begin
      cap_seg_q <= seg_q;
      cap_dp_q  <= dp_in_q;
      cap_idx_q <= enb_q;
    end
  end
  always_ff @(posedge clk) begin
    if (rst) begin
      enb_q   <= '0;
      last_q  <= '0;
      seg_q   <= '0;
      dp_in_q <= 1'b0;
      state_q <= ST_IDLE;
      cnt_q   <= '0;
      stall_q <= '0;
      digit_q <= {6{DIG_BLANK}};
      dp_q    <= '0;
      mask_q  <= '0;
      err_q   <= 1'b0;
      fv_q    <= 1'b0;
      hour_q  <= '0;
      min_q   <= '0;
      sec_q   <= '0;
    end else begin
      enb_q   <= (ENB_ACT_LOW != 0) ? ~i_seg_enb : i_seg_enb;
      seg_q   <= (SEG_ACT_LOW != 0) ? ~i_seg : i_seg;
      dp_in_q <= (SEG_ACT_LOW != 0) ? ~i_seg_dp : i_seg_dp;
      last_q  <= enb_q;
      state_q <= state_d;
      cnt_q   <= cnt_d;
      stall_q <= (onehot && chg) ? '0 : (stall_q == TW'(TIMEOUT_CYC)) ? stall_q : stall_q + TW'(1);
      digit_q <= digit_d;
      dp_q    <= dp_d;
      mask_q  <= frame ? 6'd0 : mask_d;
      err_q   <= err_q | multi | (capture & illegal);
      fv_q    <= frame;
      if (frame) begin
        hour_q <= bcd2_to_bin(digit_d[IDX_H10], digit_d[IDX_H0]);
        min_q  <= bcd2_to_bin(digit_d[IDX_M10], digit_d[IDX_M0]);
        sec_q  <= bcd2_to_bin(digit_d[IDX_S10], digit_d[IDX_S0]);
      end
    end
  end
`ifdef FND_SCAN_RX_BLINK_HOLD_EN
  always_ff @(posedge clk) blank_q <= rst ? 6'd0 : blank_d;
  assign o_blank = blank_q;
`endif
  assign o_digit       = digit_q;
  assign o_dp          = dp_q;
  assign o_hour        = hour_q;
  assign o_min         = min_q;
  assign o_sec         = sec_q;
  assign o_frame_valid = fv_q;
  assign o_err         = err_q;
  assign o_stall       = stall_q == TW'(TIMEOUT_CYC);
endmodule

// File: tb/tb_fnd_scan_rx.sv
// tb_fnd_scan_rx: directed scans against hand-computed digit, binary, error and stall results.
module tb_fnd_scan_rx;
  localparam logic [6:0] S1 = 7'h06, S2 = 7'h5B, S3 = 7'h4F, S4 = 7'h66, S5 = 7'h6D, S6 = 7'h7D;
  localparam logic [6:0] S7 = 7'h07, S9 = 7'h6F, SB = 7'h00, SX = 7'h49;
  logic clk = 1'b0, rst, i_seg_dp, o_frame_valid, o_err, o_stall;
  logic [5:0] i_seg_enb, o_dp;
  logic [6:0] i_seg, o_hour, o_min, o_sec;
  logic [23:0] o_digit;
`ifdef FND_SCAN_RX_BLINK_HOLD_EN
  logic [5:0] o_blank;
`endif
  int n_chk = 0, n_fail = 0, frames = 0;
  fnd_scan_rx #(.TIMEOUT_CYC(100)) dut (
    .clk(clk), .rst(rst), .i_seg_enb(i_seg_enb), .i_seg(i_seg), .i_seg_dp(i_seg_dp),
    .o_digit(o_digit), .o_dp(o_dp), .o_hour(o_hour), .o_min(o_min), .o_sec(o_sec),
    .o_frame_valid(o_frame_valid), .o_err(o_err), .o_stall(o_stall)
`ifdef FND_SCAN_RX_BLINK_HOLD_EN
    , .o_blank(o_blank)
`endif
  );
  always #5 clk = ~clk;
  always @(negedge clk) if (o_frame_valid === 1'b1) frames++;
  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_chk++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask
  task automatic show(input int idx, input logic [6:0] s, input logic d, input int n);
    i_seg_enb = ~(6'b1 << idx);
    i_seg = s;
    i_seg_dp = d;
    repeat (n) @(negedge clk);
  endtask
  task automatic off(input int n);
    i_seg_enb = 6'h3F;
    i_seg = SB;
    i_seg_dp = 1'b0;
    repeat (n) @(negedge clk);
  endtask
  task automatic scan6(input logic [41:0] pats, input logic [5:0] dps);
    for (int i = 5; i >= 0; i--) show(i, pats[i*7 +: 7], dps[i], 8);
  endtask
  initial begin
    rst = 1'b1;
    off(3);
    rst = 1'b0;
    @(negedge clk);
    chk("rst_digit", o_digit, 24'hFFFFFF);
    chk("rst_dp", o_dp, 0);
    chk("rst_hour", o_hour, 0);
    chk("rst_min", o_min, 0);
    chk("rst_sec", o_sec, 0);
    chk("rst_fv", o_frame_valid, 0);
    chk("rst_err", o_err, 0);
    chk("rst_stall", o_stall, 0);
    scan6({S1, S2, S3, S4, S5, S6}, 6'b010100);
    off(4);
    chk("t1_frames", frames, 1);
    chk("t1_digit", o_digit, 24'h123456);
    chk("t1_hour", o_hour, 12);
    chk("t1_min", o_min, 34);
    chk("t1_sec", o_sec, 56);
    chk("t1_dp", o_dp, 6'b010100);
    chk("t1_err", o_err, 0);
    chk("t1_fv_low", o_frame_valid, 0);
    show(0, S9, 1'b0, 3);
    off(6);
    chk("t2_digit", o_digit, 24'h123456);
    chk("t2_frames", frames, 1);
    i_seg_enb = 6'b111100;
    i_seg = S7;
    repeat (10) @(negedge clk);
    chk("t3_err", o_err, 1);
    off(4);
    chk("t3_digit", o_digit, 24'h123456);
    chk("t3_frames", frames, 1);
    show(5, S1, 1'b0, 8);
    show(4, S2, 1'b0, 8);
    show(3, S3, 1'b0, 8);
    rst = 1'b1;
    off(2);
    rst = 1'b0;
    @(negedge clk);
    chk("t6_rst_digit", o_digit, 24'hFFFFFF);
    chk("t6_rst_err", o_err, 0);
    chk("t6_rst_frames", frames, 1);
    scan6({S1, S2, SB, SB, S5, S6}, 6'b0);
    off(4);
    chk("t6_frames", frames, 2);
    chk("t6_digit", o_digit, 24'h12FF56);
    chk("t6_hour", o_hour, 12);
    chk("t6_min", o_min, 0);
    chk("t6_sec", o_sec, 56);
    chk("t6_err", o_err, 0);
`ifdef FND_SCAN_RX_BLINK_HOLD_EN
    chk("t6_blank", o_blank, 6'b001100);
`endif
    scan6({S1, S2, S3, SX, S5, S6}, 6'b0);
    off(4);
    chk("t4_frames", frames, 3);
    chk("t4_digit", o_digit, 24'h123E56);
    chk("t4_err", o_err, 1);
    chk("t4_min", o_min, 30);
    show(2, S4, 1'b0, 100);
    chk("t5_stall_early", o_stall, 0);
    repeat (2) @(negedge clk);
    chk("t5_stall_set", o_stall, 1);
    show(1, S5, 1'b0, 1);
    chk("t5_stall_hold", o_stall, 1);
    @(negedge clk);
    chk("t5_stall_clr", o_stall, 0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
